// File: rtl/key_move_decoder.sv
// PS/2 scan-code decoder: turns make/break byte sequences into held-key levels
// for left/right movement and an action button, with last-pressed-wins arbitration.
module key_move_decoder #(
    parameter logic [7:0]  LEFT_CODE      = 8'h6B,
    parameter bit          LEFT_EXT       = 1'b1,
    parameter logic [7:0]  RIGHT_CODE     = 8'h74,
    parameter bit          RIGHT_EXT      = 1'b1,
    parameter logic [7:0]  BTN_CODE       = 8'h29,
    parameter bit          BTN_EXT        = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 650000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       m_left,
    output logic       m_right,
    output logic       button_pressed,
    output logic       key_event
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StExt, StBreak, StExtBreak} state_e;

    state_e        state_q, state_d;
    logic          held_l_q, held_l_d;
    logic          held_r_q, held_r_d;
    logic          held_b_q, held_b_d;
    logic          last_left_q, last_left_d;  // 1: left is the newer direction
    logic [TW-1:0] cnt_q, cnt_d;
    logic          ext, brk;
    logic          m_left_d, m_right_d;

    assign ext = (state_q == StExt) || (state_q == StExtBreak);
    assign brk = (state_q == StBreak) || (state_q == StExtBreak);

    always_comb begin
        state_d     = state_q;
        held_l_d    = held_l_q;
        held_r_d    = held_r_q;
        held_b_d    = held_b_q;
        last_left_d = last_left_q;
        cnt_d       = '0;
        if (rx_valid) begin
            if (rx_data == 8'hE0) begin
                state_d = StExt;
            end else if (rx_data == 8'hF0) begin
                if (state_q == StIdle)     state_d = StBreak;
                else if (state_q == StExt) state_d = StExtBreak;
            end else if (rx_data == 8'h00 || rx_data == 8'hFF) begin
                held_l_d = 1'b0;
                held_r_d = 1'b0;
                held_b_d = 1'b0;
                state_d  = StIdle;
            end else begin
                state_d = StIdle;
                if (rx_data == LEFT_CODE && ext == LEFT_EXT) begin
                    if (!brk && !held_l_q) last_left_d = 1'b1;
                    held_l_d = !brk;
                end
                if (rx_data == RIGHT_CODE && ext == RIGHT_EXT) begin
                    if (!brk && !held_r_q) last_left_d = 1'b0;
                    held_r_d = !brk;
                end
                if (rx_data == BTN_CODE && ext == BTN_EXT) begin
                    held_b_d = !brk;
                end
            end
        end else if (state_q != StIdle) begin
            // Abandon a stalled prefix; held keys are kept.
            if (cnt_q == TIMEOUT_LAST) state_d = StIdle;
            else                       cnt_d   = cnt_q + 1'b1;
        end
    end

    assign m_left_d  = held_l_d & (~held_r_d | last_left_d);
    assign m_right_d = held_r_d & (~held_l_d | ~last_left_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            held_l_q       <= 1'b0;
            held_r_q       <= 1'b0;
            held_b_q       <= 1'b0;
            last_left_q    <= 1'b0;
            cnt_q          <= '0;
            m_left         <= 1'b0;
            m_right        <= 1'b0;
            button_pressed <= 1'b0;
            key_event      <= 1'b0;
        end else begin
            state_q        <= state_d;
            held_l_q       <= held_l_d;
            held_r_q       <= held_r_d;
            held_b_q       <= held_b_d;
            last_left_q    <= last_left_d;
            cnt_q          <= cnt_d;
            m_left         <= m_left_d;
            m_right        <= m_right_d;
            button_pressed <= held_b_d;
            key_event      <= {m_left_d, m_right_d, held_b_d} !=
                              {m_left, m_right, button_pressed};
        end
    end

endmodule

// File: tb/tb_key_move_decoder.sv
// Directed bench for key_move_decoder; outputs checked on the falling edge
// as {m_left, m_right, button_pressed, key_event}.
module tb_key_move_decoder;

    localparam int unsigned T = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       m_left, m_right, button_pressed, key_event;

    int compared = 0;
    int mismatched = 0;

    key_move_decoder #(.TIMEOUT_CYCLES(T)) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .m_left         (m_left),
        .m_right        (m_right),
        .button_pressed (button_pressed),
        .key_event      (key_event)
    );

    always #5 clk = ~clk;

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = {m_left, m_right, button_pressed, key_event};
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%b expected=%b (ml,mr,btn,ev)", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        check("reset", 4'b0000);

        // Left make / break.
        send_byte(8'hE0);           check("e0_no_change", 4'b0000);
        send_byte(8'h6B);           check("left_make", 4'b1001);
        @(negedge clk);             check("event_one_cycle", 4'b1000);
        send_byte(8'hE0); send_byte(8'hF0);
        send_byte(8'h6B);           check("left_break", 4'b0001);

        // Arbitration and handback.
        send_byte(8'hE0); send_byte(8'h74); check("right_make", 4'b0101);
        send_byte(8'hE0); send_byte(8'h6B); check("left_over_right", 4'b1001);
        send_byte(8'hE0); send_byte(8'hF0);
        send_byte(8'h6B);           check("handback_right", 4'b0101);
        for (int i = 0; i < 5; i++) begin
            send_byte(8'hE0); send_byte(8'h74); check("right_repeat", 4'b0100);
        end

        // Button alongside direction.
        send_byte(8'h29);           check("btn_make", 4'b0111);
        send_byte(8'hF0); send_byte(8'h29); check("btn_break", 4'b0101);
        send_byte(8'hE0); send_byte(8'hF0);
        send_byte(8'h74);           check("right_break", 4'b0001);

        // Wrong extension flag is ignored.
        send_byte(8'h6B);           check("plain_6b_ignored", 4'b0000);
        send_byte(8'hE0); send_byte(8'h29); check("ext_29_ignored", 4'b0000);
        send_byte(8'hAA);           check("aa_ignored", 4'b0000);
        send_byte(8'hE0); send_byte(8'h74); check("right_after_ignored", 4'b0101);
        send_byte(8'hE0); send_byte(8'hF0);
        send_byte(8'h74);           check("right_break2", 4'b0001);

        // Prefix timeout: T idle cycles abandons E0, T-2 does not.
        send_byte(8'hE0); idle(T - 1);
        send_byte(8'h6B);           check("timeout_expired", 4'b0000);
        send_byte(8'hE0); idle(T - 3);
        send_byte(8'h6B);           check("timeout_not_yet", 4'b1001);

        // Error byte clears everything.
        send_byte(8'h29);           check("left_and_btn", 4'b1011);
        send_byte(8'hFF);           check("ff_clears", 4'b0001);

        // Reset between prefix and code.
        send_byte(8'hE0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("mid_reset", 4'b0000);
        send_byte(8'h6B);           check("prefix_dropped", 4'b0000);

        // Reset wins over a simultaneous strobe.
        @(negedge clk); rst = 1'b1; rx_valid = 1'b1; rx_data = 8'hE0;
        @(negedge clk); rst = 1'b0; rx_valid = 1'b0;
        send_byte(8'h6B);           check("rst_beats_valid", 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/key_move_decoder.md
Name: key_move_decoder

Overview:
- Sits directly upstream of the player movement controller.
- Converts the byte stream from the PS/2 keyboard receiver into level signals for held keys: m_left, m_right and button_pressed.
- Tracks make/break codes, including E0-extended codes, and arbitrates left/right so that only one direction is asserted at a time.
- All outputs are registered and stable between scan-code events, so the movement controller can sample them on its own v_tick.

Parameters:
- LEFT_CODE, 8'h6B, scan code of the left key (arrow left).
- LEFT_EXT, 1, 1 means the left key requires the E0 prefix.
- RIGHT_CODE, 8'h74, scan code of the right key (arrow right).
- RIGHT_EXT, 1, 1 means the right key requires the E0 prefix.
- BTN_CODE, 8'h29, scan code of the action key (space).
- BTN_EXT, 0, 1 means the action key requires the E0 prefix.
- TIMEOUT_CYCLES, 650000, number of idle cycles allowed inside a prefix sequence before it is abandoned (10 ms at 65 MHz).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- rx_data  in  8  received scan-code byte; valid only while rx_valid=1
- rx_valid  in  1  one-cycle strobe marking a new byte
- m_left  out  1  left move request (held level)
- m_right  out  1  right move request (held level)
- button_pressed  out  1  action key held
- key_event  out  1  one-cycle pulse whenever any of the three outputs changes

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE; held_l, held_r, held_b=0; last_dir=RIGHT; timeout counter=0.
  - All outputs 0.
  - Reset mid-sequence discards any partial prefix.
- FSM states: IDLE, EXT, BREAK, EXT_BREAK. The FSM advances only on cycles where rx_valid=1.
- Prefix handling:
  - E0 in any state -> EXT.
  - F0 in IDLE -> BREAK; F0 in EXT -> EXT_BREAK; F0 in BREAK or EXT_BREAK -> stay.
- Final byte (any value other than E0/F0/00/FF):
  - Compute ext = (state is EXT or EXT_BREAK) and brk = (state is BREAK or EXT_BREAK).
  - A key matches only if both the code and the ext flag equal that key's parameters. Example: non-extended 6B is NOT left.
  - On a match, the key's held bit is set (make) or cleared (break).
  - State returns to IDLE in every case.
  - Unmatched codes, including AA, FA and EE, are ignored apart from the return to IDLE.
- Overrun/error bytes 00 or FF, in any state: clear held_l, held_r and held_b; state -> IDLE.
- Timeout:
  - The counter increments every cycle while state is not IDLE and resets on every rx_valid.
  - When it reaches TIMEOUT_CYCLES-1, state -> IDLE and held bits are unchanged.
  - The counter is held at 0 in IDLE. Width is $clog2(TIMEOUT_CYCLES).
- Direction arbitration:
  - A make of left while held_l=0 sets last_dir=LEFT; a make of right while held_r=0 sets last_dir=RIGHT.
  - Typematic repeats (make of an already-held key) do not change last_dir.
  - m_left = held_l & (~held_r | last_dir==LEFT); m_right = held_r & (~held_l | last_dir==RIGHT).
  - m_left and m_right are never both 1.
  - Releasing the newer direction while the older is still held hands control back to the older one.
- button_pressed = held_b, independent of direction.
- Latency and output registering:
  - Outputs are registered. A final byte strobed at cycle N gives updated outputs at cycle N+1.
  - key_event is 1 at cycle N+1 iff {m_left, m_right, button_pressed} differ from their values at cycle N.
  - Repeats produce no key_event.
- Simultaneous events: with rst=1 and rx_valid=1 together, reset wins and the byte is dropped.

Test Plan:
- Reset, then E0,6B -> m_left=1 one cycle after the 6B strobe, with a key_event pulse. Then E0,F0,6B -> m_left=0, with a key_event pulse.
- E0,74 then E0,6B (both held) -> m_right=1 then m_left=1/m_right=0. Then E0,F0,6B -> m_right=1 again. Repeat E0,74 x5 -> no key_event and outputs unchanged.
- 29 -> button_pressed=1 while E0,74 is also held (m_right=1, button=1). Then F0,29 -> button_pressed=0 and m_right stays 1.
- Non-extended 6B, and E0,29 -> no output change, no key_event, state back to IDLE (a following E0,74 works normally).
- E0 followed by TIMEOUT_CYCLES idle cycles, then 6B -> treated as non-extended, so no m_left. Same test with the gap at TIMEOUT_CYCLES-2 -> m_left=1.
- Hold left and button, then send FF -> all outputs 0 with a key_event pulse. Separately: assert rst between E0 and 6B -> 6B alone gives no m_left.
